// File: rtl/video_pack_pkg.sv
// rtl/video_pack_pkg.sv - FSM states, pack layout helpers and colour-bar table for video_packer
package video_pack_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2,
        HBLANK  = 2'd3
    } vp_state_t;

    localparam int COLOR_W = 8;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int FLAG_W  = 4;

    // Pack is {vs,hs,de,sof,rgb,x,y}; offsets depend on the geometry-derived coordinate widths.
    function automatic int pack_size(input int x_w, input int y_w);
        return RGB_W + FLAG_W + x_w + y_w;
    endfunction

    function automatic int off_x(input int y_w);
        return y_w;
    endfunction

    function automatic int off_rgb(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    function automatic int off_flags(input int x_w, input int y_w);
        return x_w + y_w + RGB_W;
    endfunction

    // Index 0 is the leftmost bar.
    localparam logic [7:0][RGB_W-1:0] BAR_TABLE = {
        24'h000000,  // black
        24'h0000FF,  // blue
        24'hFF0000,  // red
        24'hFF00FF,  // magenta
        24'h00FF00,  // green
        24'h00FFFF,  // cyan
        24'hFFFF00,  // yellow
        24'hFFFFFF   // white
    };

endpackage

// File: rtl/video_geom_counter.sv
// rtl/video_geom_counter.sv - pixel coordinates, raw line length and line/frame geometry checks
module video_geom_counter
    import video_pack_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int X_W   = $clog2(H_ACT),
    parameter int Y_W   = $clog2(V_ACT)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_de,
    input  logic           i_de_rise,
    input  logic           i_line_end,
    input  logic           i_vs_edge,
    input  logic           i_in_active,
    input  logic           i_in_wait,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_err,
    output logic           o_frame_ok,
    output logic [7:0]     o_frame_cnt
);

    localparam int RAW_W  = X_W + 1;
    localparam int LCNT_W = Y_W + 1;
    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACT - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACT - 1);

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [RAW_W-1:0]  r_raw;
    logic [LCNT_W-1:0] r_line_cnt;
    logic              r_bad_frame;
    logic              r_line_err;
    logic              r_frame_ok;
    logic [7:0]        r_frame_cnt;
    logic [X_W-1:0]    w_x;
    logic              w_raw_bad;

    always_comb begin
        w_x = '0;
        if (i_de && !i_de_rise) begin
            w_x = (r_x == X_MAX) ? r_x : r_x + X_W'(1);
        end
    end

    assign w_raw_bad = (r_raw != RAW_W'(H_ACT));

    // The truncated line of a vs edge in ACTIVE never reaches i_line_end, so it cannot pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x         <= '0;
            r_y         <= '0;
            r_raw       <= '0;
            r_line_cnt  <= '0;
            r_bad_frame <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_x        <= w_x;
            r_line_err <= 1'b0;
            if (i_de_rise) begin
                r_raw <= RAW_W'(1);
            end else if (i_de) begin
                r_raw <= r_raw + RAW_W'(1);
            end
            if (i_vs_edge) begin
                r_frame_ok  <= !r_bad_frame && (r_line_cnt == LCNT_W'(V_ACT))
                               && !i_in_active && !i_in_wait;
                r_bad_frame <= 1'b0;
                r_line_cnt  <= '0;
                r_y         <= '0;
                if (!i_in_wait) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end else if (i_line_end) begin
                r_line_cnt <= r_line_cnt + LCNT_W'(1);
                r_y        <= (r_y == Y_MAX) ? r_y : r_y + Y_W'(1);
                if (w_raw_bad) begin
                    r_line_err  <= 1'b1;
                    r_bad_frame <= 1'b1;
                end
            end
        end
    end

    assign o_x         = w_x;
    assign o_y         = i_vs_edge ? '0 : r_y;
    assign o_line_err  = r_line_err;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/video_packer.sv
// rtl/video_packer.sv - sync/DE/RGB888 to pixel pack front end; VIDEO_PACKER_PATTERN_EN adds colour bars
module video_packer
    import video_pack_pkg::*;
#(
    parameter int   H_ACT     = 1280,
    parameter int   V_ACT     = 720,
    parameter logic VS_POL    = 1'b1,
    localparam int  X_W       = $clog2(H_ACT),
    localparam int  Y_W       = $clog2(V_ACT),
    localparam int  PACK_SIZE = 3*8 + 4 + $clog2(H_ACT) + $clog2(V_ACT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_vsync,
    input  logic                 i_hsync,
    input  logic                 i_de,
    input  logic [7:0]           i_r,
    input  logic [7:0]           i_g,
    input  logic [7:0]           i_b,
`ifdef VIDEO_PACKER_PATTERN_EN
    input  logic                 i_pattern,
`endif
    output logic [PACK_SIZE-1:0] o_pack,
    output logic                 o_frame_ok,
    output logic                 o_line_err,
    output logic [7:0]           o_frame_cnt
);

    localparam int OFF_X     = off_x(Y_W);
    localparam int OFF_RGB   = off_rgb(X_W, Y_W);
    localparam int OFF_FLAGS = off_flags(X_W, Y_W);

    logic                 r_vs_prev;
    logic                 r_de_prev;
    vp_state_t            r_state;
    vp_state_t            w_state_nxt;
    logic                 w_vs_edge;
    logic                 w_de_rise;
    logic                 w_de_fall;
    logic                 w_line_end;
    logic                 w_sof;
    logic                 w_in_wait;
    logic                 w_in_active;
    logic                 w_de_out;
    logic [X_W-1:0]       w_x;
    logic [Y_W-1:0]       w_y;
    logic [X_W-1:0]       w_x_out;
    logic [Y_W-1:0]       w_y_out;
    logic [RGB_W-1:0]     w_rgb;
    logic [PACK_SIZE-1:0] w_pack;
    logic [PACK_SIZE-1:0] r_pack;

    assign w_vs_edge   = (i_vsync == VS_POL) && (r_vs_prev != VS_POL);
    assign w_de_rise   = i_de && !r_de_prev;
    assign w_de_fall   = !i_de && r_de_prev;
    assign w_in_wait   = (r_state == WAIT_VS);
    assign w_in_active = (r_state == ACTIVE);
    assign w_line_end  = w_in_active && w_de_fall && !w_vs_edge;
    assign w_sof       = (r_state == VBLANK) && w_de_rise && !w_vs_edge;

    // Previous vsync resets to the active level so a vsync held active through reset is not an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_prev <= VS_POL;
            r_de_prev <= 1'b0;
            r_state   <= WAIT_VS;
        end else begin
            r_vs_prev <= i_vsync;
            r_de_prev <= i_de;
            r_state   <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_VS: if (w_vs_edge) w_state_nxt = VBLANK;
            VBLANK:  if (!w_vs_edge && w_de_rise) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_vs_edge) w_state_nxt = VBLANK;
                     else if (w_de_fall) w_state_nxt = HBLANK;
            HBLANK:  if (w_vs_edge) w_state_nxt = VBLANK;
                     else if (w_de_rise) w_state_nxt = ACTIVE;
            default: w_state_nxt = WAIT_VS;
        endcase
    end

    video_geom_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_geom (
        .clk         (clk),
        .rstn        (rstn),
        .i_de        (i_de),
        .i_de_rise   (w_de_rise),
        .i_line_end  (w_line_end),
        .i_vs_edge   (w_vs_edge),
        .i_in_active (w_in_active),
        .i_in_wait   (w_in_wait),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_line_err  (o_line_err),
        .o_frame_ok  (o_frame_ok),
        .o_frame_cnt (o_frame_cnt)
    );

    assign w_de_out = i_de && !w_in_wait;
    assign w_x_out  = w_in_wait ? '0 : w_x;
    assign w_y_out  = w_in_wait ? '0 : w_y;

`ifdef VIDEO_PACKER_PATTERN_EN
    logic r_pat_en;

    // Latched only on the vs edge so a frame is never split between camera and bars.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pat_en <= 1'b0;
        end else if (w_vs_edge) begin
            r_pat_en <= i_pattern;
        end
    end

    assign w_rgb = r_pat_en ? BAR_TABLE[w_x_out[X_W-1 -: 3]] : {i_r, i_g, i_b};
`else
    assign w_rgb = {i_r, i_g, i_b};
`endif

    always_comb begin
        w_pack                       = '0;
        w_pack[OFF_FLAGS + 3]        = i_vsync;
        w_pack[OFF_FLAGS + 2]        = i_hsync;
        w_pack[OFF_FLAGS + 1]        = w_de_out;
        w_pack[OFF_FLAGS]            = w_sof;
        w_pack[OFF_RGB +: RGB_W]     = w_rgb;
        w_pack[OFF_X +: X_W]         = w_x_out;
        w_pack[Y_W-1:0]              = w_y_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack <= '0;
        end else begin
            r_pack <= w_pack;
        end
    end

    assign o_pack = r_pack;

endmodule

// File: tb/tb_video_packer.sv
// tb/tb_video_packer.sv - directed self-checking bench for video_packer (1280-wide, 4-line frames)
module tb_video_packer;

    localparam int H  = 1280;
    localparam int V  = 4;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int PW = 24 + 4 + XW + YW;
    localparam int HB = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_hsync = 1'b0;
    logic          i_de = 1'b0;
    logic [7:0]    i_r = 8'd0;
    logic [7:0]    i_g = 8'd0;
    logic [7:0]    i_b = 8'd0;
`ifdef VIDEO_PACKER_PATTERN_EN
    logic          i_pattern = 1'b0;
`endif
    logic [PW-1:0] o_pack;
    logic          o_frame_ok;
    logic          o_line_err;
    logic [7:0]    o_frame_cnt;

    logic [YW-1:0] pk_y;
    logic [XW-1:0] pk_x;
    logic [23:0]   pk_rgb;
    logic          pk_sof;
    logic          pk_de;
    logic          pk_hs;
    logic          pk_vs;

    assign pk_y   = o_pack[YW-1:0];
    assign pk_x   = o_pack[YW +: XW];
    assign pk_rgb = o_pack[YW+XW +: 24];
    assign pk_sof = o_pack[YW+XW+24];
    assign pk_de  = o_pack[YW+XW+25];
    assign pk_hs  = o_pack[YW+XW+26];
    assign pk_vs  = o_pack[YW+XW+27];

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    int mon_lerr = 0;
    int mon_sof = 0;
    int mon_de = 0;
    int mon_xsat = 0;

    video_packer #(.H_ACT(H), .V_ACT(V)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_vsync     (i_vsync),
        .i_hsync     (i_hsync),
        .i_de        (i_de),
        .i_r         (i_r),
        .i_g         (i_g),
        .i_b         (i_b),
`ifdef VIDEO_PACKER_PATTERN_EN
        .i_pattern   (i_pattern),
`endif
        .o_pack      (o_pack),
        .o_frame_ok  (o_frame_ok),
        .o_line_err  (o_line_err),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_line_err) mon_lerr <= mon_lerr + 1;
        if (pk_sof) mon_sof <= mon_sof + 1;
        if (pk_de) mon_de <= mon_de + 1;
        if (pk_de && pk_x == XW'(H - 1)) mon_xsat <= mon_xsat + 1;
    end

    function automatic logic [23:0] pix(input int l, input int p);
        logic [31:0] a;
        a = p;
        return {a[7:0], a[10:3], 8'(l) ^ 8'hA5};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input logic [23:0] rgb);
        i_de = de;
        {i_r, i_g, i_b} = rgb;
    endtask

    task automatic vs_pulse();
        drive(1'b0, 24'h0);
        i_vsync = 1'b1;
        repeat (3) tick();
        i_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic blank();
        drive(1'b0, 24'h0);
        i_hsync = 1'b1;
        repeat (4) tick();
        i_hsync = 1'b0;
        repeat (HB - 4) tick();
    endtask

    task automatic send_line(input int l, input int len);
        for (int p = 0; p < len; p++) begin
            drive(1'b1, pix(l, p));
            tick();
        end
        blank();
    endtask

    task automatic send_frame();
        for (int l = 0; l < V; l++) send_line(l, H);
    endtask

    task automatic test_reset();
        int de0;
        repeat (3) tick();
        total++; if (o_pack !== '0) begin bad++; $display("FAIL reset_pack: got %0h expected 0", o_pack); end
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL reset_ok: got %b expected 0", o_frame_ok); end
        total++; if (o_line_err !== 1'b0) begin bad++; $display("FAIL reset_lerr: got %b expected 0", o_line_err); end
        total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", o_frame_cnt); end
        rstn = 1'b1;
        de0 = mon_de;
        for (int p = 0; p < 100; p++) begin drive(1'b1, pix(9, p)); tick(); end
        rstn = 1'b0;
        #1;
        total++; if (o_pack !== '0) begin bad++; $display("FAIL midline_reset_pack: got %0h expected 0", o_pack); end
        repeat (2) tick();
        rstn = 1'b1;
        for (int p = 0; p < 50; p++) begin drive(1'b1, pix(9, p)); tick(); end
        drive(1'b0, 24'h0);
        repeat (10) tick();
        total++; if (mon_de - de0 !== 0) begin bad++; $display("FAIL wait_vs_de: got %0d de cycles expected 0", mon_de - de0); end
        vs_pulse();
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL edge1_ok: got %b expected 0", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'd0) begin bad++; $display("FAIL edge1_cnt: got %0d expected 0", o_frame_cnt); end
        send_frame();
        vs_pulse();
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL edge2_ok: got %b expected 1", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'd1) begin bad++; $display("FAIL edge2_cnt: got %0d expected 1", o_frame_cnt); end
        send_frame();
        vs_pulse();
        exp_cnt = 2;
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL edge3_ok: got %b expected 1", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'd2) begin bad++; $display("FAIL edge3_cnt: got %0d expected 2", o_frame_cnt); end
    endtask

    task automatic test_clean_frame();
        int sof0, lerr0, px_bad;
        sof0 = mon_sof; lerr0 = mon_lerr; px_bad = 0;
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) begin
                drive(1'b1, pix(l, p));
                tick();
                if (pk_x !== XW'(p) || pk_y !== YW'(l) || pk_rgb !== pix(l, p) || pk_de !== 1'b1) px_bad++;
                if (l == 0 && p == 0) begin
                    total++; if ({pk_sof, pk_x, pk_y} !== {1'b1, XW'(0), YW'(0)}) begin bad++; $display("FAIL first_pixel: got sof=%b x=%0d y=%0d expected sof=1 x=0 y=0", pk_sof, pk_x, pk_y); end
                end
                if (l == V - 1 && p == H - 1) begin
                    total++; if ({pk_sof, pk_x, pk_y, pk_rgb} !== {1'b0, XW'(H - 1), YW'(V - 1), pix(l, p)}) begin bad++; $display("FAIL last_pixel: got sof=%b x=%0d y=%0d rgb=%0h expected sof=0 x=%0d y=%0d rgb=%0h", pk_sof, pk_x, pk_y, pk_rgb, H - 1, V - 1, pix(l, p)); end
                end
            end
            if (l == V - 1) begin
                drive(1'b0, 24'h0);
                i_hsync = 1'b1;
                tick();
                total++; if ({pk_hs, pk_de, pk_x, pk_y} !== {1'b1, 1'b0, XW'(0), YW'(V - 1)}) begin bad++; $display("FAIL hblank_pack: got hs=%b de=%b x=%0d y=%0d expected hs=1 de=0 x=0 y=%0d", pk_hs, pk_de, pk_x, pk_y, V - 1); end
                i_hsync = 1'b0;
            end
            blank();
        end
        total++; if (px_bad !== 0) begin bad++; $display("FAIL pixel_stream: got %0d bad pixels expected 0", px_bad); end
        total++; if (mon_sof - sof0 !== 1) begin bad++; $display("FAIL sof_count: got %0d expected 1", mon_sof - sof0); end
        total++; if (mon_lerr - lerr0 !== 0) begin bad++; $display("FAIL clean_lerr: got %0d expected 0", mon_lerr - lerr0); end
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL clean_ok: got %b expected 1", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL clean_cnt: got %0d expected %0d", o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_short_line();
        int lerr0;
        lerr0 = mon_lerr;
        send_line(0, H);
        for (int p = 0; p < H - 1; p++) begin drive(1'b1, pix(1, p)); tick(); end
        drive(1'b0, 24'h0);
        tick();
        total++; if (o_line_err !== 1'b1) begin bad++; $display("FAIL short_lerr: got %b expected 1", o_line_err); end
        tick();
        total++; if (o_line_err !== 1'b0) begin bad++; $display("FAIL short_lerr_width: got %b expected 0", o_line_err); end
        blank();
        send_line(2, H);
        send_line(3, H);
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL short_ok: got %b expected 0", o_frame_ok); end
        total++; if (mon_lerr - lerr0 !== 1) begin bad++; $display("FAIL short_lerr_count: got %0d expected 1", mon_lerr - lerr0); end
        send_frame();
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL recover_ok: got %b expected 1", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL recover_cnt: got %0d expected %0d", o_frame_cnt, exp_cnt); end
    endtask

    task automatic test_long_line();
        int xs0;
        xs0 = mon_xsat;
        for (int p = 0; p < H + 20; p++) begin drive(1'b1, pix(0, p)); tick(); end
        drive(1'b0, 24'h0);
        tick();
        total++; if (o_line_err !== 1'b1) begin bad++; $display("FAIL long_lerr: got %b expected 1", o_line_err); end
        blank();
        total++; if (mon_xsat - xs0 !== 21) begin bad++; $display("FAIL long_xsat: got %0d clks expected 21", mon_xsat - xs0); end
        for (int l = 1; l < V; l++) send_line(l, H);
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL long_ok: got %b expected 0", o_frame_ok); end
    endtask

    task automatic test_extra_line();
        send_frame();
        drive(1'b1, pix(V, 0));
        tick();
        total++; if (pk_y !== YW'(V - 1)) begin bad++; $display("FAIL y_saturate: got %0d expected %0d", pk_y, V - 1); end
        for (int p = 1; p < H; p++) begin drive(1'b1, pix(V, p)); tick(); end
        blank();
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL extra_ok: got %b expected 0", o_frame_ok); end
    endtask

    task automatic test_vs_collision();
        int sof0, lerr0;
        repeat (4) tick();
        sof0 = mon_sof;
        i_vsync = 1'b1;
        drive(1'b1, pix(0, 0));
        tick();
        exp_cnt++;
        total++; if ({pk_vs, pk_de, pk_sof} !== 3'b110) begin bad++; $display("FAIL vs_derise_pack: got vs=%b de=%b sof=%b expected vs=1 de=1 sof=0", pk_vs, pk_de, pk_sof); end
        repeat (2) tick();
        i_vsync = 1'b0;
        repeat (5) tick();
        blank();
        total++; if (mon_sof - sof0 !== 0) begin bad++; $display("FAIL vs_derise_sof: got %0d expected 0", mon_sof - sof0); end
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL vs_derise_ok: got %b expected 0", o_frame_ok); end
        send_line(0, H);
        send_line(1, H);
        sof0 = mon_sof; lerr0 = mon_lerr;
        for (int p = 0; p < 100; p++) begin drive(1'b1, pix(2, p)); tick(); end
        i_vsync = 1'b1;
        for (int p = 100; p < 120; p++) begin
            drive(1'b1, pix(2, p));
            tick();
            if (p == 102) i_vsync = 1'b0;
        end
        exp_cnt++;
        blank();
        total++; if (o_frame_ok !== 1'b0) begin bad++; $display("FAIL vs_active_ok: got %b expected 0", o_frame_ok); end
        total++; if (mon_lerr - lerr0 !== 0) begin bad++; $display("FAIL vs_active_lerr: got %0d expected 0", mon_lerr - lerr0); end
        total++; if (mon_sof - sof0 !== 0) begin bad++; $display("FAIL vs_active_sof: got %0d expected 0", mon_sof - sof0); end
        send_frame();
        vs_pulse();
        exp_cnt++;
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL vs_recover_ok: got %b expected 1", o_frame_ok); end
        total++; if (o_frame_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL vs_recover_cnt: got %0d expected %0d", o_frame_cnt, exp_cnt); end
    endtask

`ifdef VIDEO_PACKER_PATTERN_EN
    task automatic test_pattern();
        send_line(0, H);
        i_pattern = 1'b1;
        for (int p = 0; p < H; p++) begin
            drive(1'b1, pix(1, p));
            tick();
            if (p == 200) begin
                total++; if (pk_rgb !== pix(1, p)) begin bad++; $display("FAIL pat_midframe: got %0h expected %0h", pk_rgb, pix(1, p)); end
            end
        end
        blank();
        send_line(2, H);
        send_line(3, H);
        vs_pulse();
        for (int p = 0; p < H; p++) begin
            drive(1'b1, pix(0, p));
            tick();
            if (p == 0 || p == 159) begin
                total++; if (pk_rgb !== 24'hFFFFFF) begin bad++; $display("FAIL pat_white_x%0d: got %0h expected ffffff", p, pk_rgb); end
            end
            if (p == 256) begin
                total++; if (pk_rgb !== 24'hFFFF00) begin bad++; $display("FAIL pat_yellow: got %0h expected ffff00", pk_rgb); end
            end
            if (p == H - 1) begin
                total++; if (pk_rgb !== 24'hFF00FF) begin bad++; $display("FAIL pat_last: got %0h expected ff00ff", pk_rgb); end
            end
        end
        blank();
        i_pattern = 1'b0;
        for (int l = 1; l < V; l++) send_line(l, H);
        vs_pulse();
        total++; if (o_frame_ok !== 1'b1) begin bad++; $display("FAIL pat_ok: got %b expected 1", o_frame_ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_short_line();
        test_long_line();
        test_extra_line();
        test_vs_collision();
`ifdef VIDEO_PACKER_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
